seg_price_display: RTL and testbench

- Display back-end for the taxi meter.
- Consumes the fare value, decimal-point mask, sign and enable from the fare generator and drives a 6-digit multiplexed seven-segment display.
- Contains a sequential double-dabble binary-to-BCD converter, optional leading-zero blanking, and a time-multiplexed digit scanner.

---
 rtl/seg_price_display.sv | 191 +++++++++++++++++++
 tb/tb_seg_price_display.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_price_display.sv
// Taxi-meter display back-end: fare -> BCD -> 6-digit muxed 7-seg.
// Optional macro SEG_BLANK_EN enables leading-zero blanking.
//
// Ports:
//   sys_clk   : system clock (50 MHz)
//   sys_rst_n : asynchronous active-low reset
//   data      : unsigned fare value, saturated at DATA_MAX
//   point     : decimal-point mask, bit i = digit i (0 = rightmost)
//   sign      : 1 = show a minus sign left of the number
//   seg_en    : 1 = display on, 0 = all digits off
//   sel       : one-hot active-high digit select
//   seg       : active-low segments {dp,g,f,e,d,c,b,a}
module seg_price_display #(
    parameter logic [15:0] CNT_SCAN = 16'd49_999,
    parameter logic [19:0] DATA_MAX = 20'd999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t      state;
    logic [19:0] bin;
    logic [23:0] bcd;
    logic [23:0] bcd_adj;
    logic [4:0]  shift_cnt;
    logic [5:0]  sh_point;
    logic        sh_sign;

    logic [23:0] disp_bcd;
    logic [5:0]  disp_point;
    logic        disp_sign;

    logic [15:0] cnt;
    logic [2:0]  idx;

    logic [5:0]  blank;
    logic [5:0]  minus;
    logic [3:0]  digit;
    logic [7:0]  seg_next;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    // Double-dabble correction applied before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Converter runs continuously; display regs update atomically in DONE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            bin        <= '0;
            bcd        <= '0;
            shift_cnt  <= '0;
            sh_point   <= '0;
            sh_sign    <= 1'b0;
            disp_bcd   <= '0;
            disp_point <= '0;
            disp_sign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bin       <= (data > DATA_MAX) ? DATA_MAX : data;
                    sh_point  <= point;
                    sh_sign   <= sign;
                    bcd       <= '0;
                    shift_cnt <= '0;
                    state     <= CONV;
                end
                CONV: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    shift_cnt  <= shift_cnt + 5'd1;
                    if (shift_cnt == 5'd19) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    disp_bcd   <= bcd;
                    disp_point <= sh_point;
                    disp_sign  <= sh_sign;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEG_BLANK_EN
    logic       run;
    logic [2:0] ms;
`endif

    // blank: digit suppressed; minus: digit carries the sign.
    always_comb begin
        blank = '0;
        minus = '0;
`ifdef SEG_BLANK_EN
        run = 1'b1;
        ms  = 3'd0;
        // Blanking stops at the first nonzero digit or set point bit.
        for (int i = 5; i >= 1; i--) begin
            run = run && (disp_bcd[i*4 +: 4] == 4'd0)
                      && !disp_point[i];
            blank[i] = run;
        end
        for (int i = 0; i < 6; i++) begin
            if (!blank[i]) begin
                ms = 3'(i);
            end
        end
        if (disp_sign && (ms < 3'd5)) begin
            minus[ms + 3'd1] = 1'b1;
        end
`else
        // Without blanking only a zero top digit can carry the sign.
        minus[5] = disp_sign && (disp_bcd[23:20] == 4'd0);
`endif
    end

    always_comb begin
        digit = disp_bcd[{idx, 2'b00} +: 4];
        if (minus[idx]) begin
            seg_next = 8'hBF;
        end else if (blank[idx]) begin
            seg_next = 8'hFF;
        end else begin
            seg_next = seg_code(digit);
        end
        if (disp_point[idx]) begin
            seg_next[7] = 1'b0;
        end
    end

    // Scanner keeps running while the display is disabled.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
            idx <= '0;
            sel <= '0;
            seg <= 8'hFF;
        end else begin
            if (cnt == CNT_SCAN) begin
                cnt <= '0;
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end
            if (seg_en) begin
                sel <= 6'd1 << idx;
                seg <= seg_next;
            end else begin
                sel <= '0;
                seg <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_price_display.sv
// Scoreboard bench for seg_price_display with a small scan period.
// Works with or without SEG_BLANK_EN defined.
module tb_seg_price_display;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         digit;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];

    seg_price_display #(
        .CNT_SCAN(16'd4),
        .DATA_MAX(20'd999_999)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .data     (data),
        .point    (point),
        .sign     (sign),
        .seg_en   (seg_en),
        .sel      (sel),
        .seg      (seg)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] code_of(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Reference: decimal digits via arithmetic, then blank/sign/dp rules.
    function automatic logic [7:0] ref_seg(
        input int         v_in,
        input logic [5:0] p,
        input logic       s,
        input int         i
    );
        int         v;
        int         dg[6];
        int         ms;
        logic [7:0] r;
        v = (v_in > 999_999) ? 999_999 : v_in;
        for (int k = 0; k < 6; k++) begin
            dg[k] = v % 10;
            v = v / 10;
        end
`ifdef SEG_BLANK_EN
        ms = 0;
        for (int k = 1; k < 6; k++) begin
            if (dg[k] != 0 || p[k]) ms = k;
        end
`else
        ms = 5;
`endif
        r = code_of(dg[i]);
        if (i > ms) r = 8'hFF;
`ifdef SEG_BLANK_EN
        if (s && ms < 5 && i == ms + 1) r = 8'hBF;
`else
        if (s && i == 5 && dg[5] == 0) r = 8'hBF;
`endif
        if (p[i]) r[7] = 1'b0;
        return r;
    endfunction

    // Monitor: per-cycle scan check plus scoreboard on each new digit.
    int         n = 0;
    logic       en_q = 1'b0;
    logic [5:0] prev_sel = '0;

    always @(posedge sys_clk) begin
        logic [5:0] exp_sel;
        int         d;
        if (!sys_rst_n) begin
            n = 0;
        end else begin
            n++;
            en_q = seg_en;
        end
        #1;
        if (sys_rst_n && n > 0) begin
            exp_sel = en_q ? (6'd1 << (((n - 1) / 5) % 6)) : 6'd0;
            tests++;
            if (sel !== exp_sel) begin
                fails++;
                $display("FAIL scan_sel n=%0d got=%b exp=%b",
                         n, sel, exp_sel);
            end
            if (!en_q) begin
                tests++;
                if (seg !== 8'hFF) begin
                    fails++;
                    $display("FAIL off_seg got=%h exp=FF", seg);
                end
            end
            if (sel != 6'd0 && sel != prev_sel) begin
                d = -1;
                for (int k = 0; k < 6; k++) begin
                    if (sel == (6'd1 << k)) d = k;
                end
                for (int k = 0; k < sb.size(); k++) begin
                    if (d >= 0 && sb[k].digit == d) begin
                        tests++;
                        if (seg !== sb[k].seg) begin
                            fails++;
                            $display("FAIL digit%0d got=%h exp=%h",
                                     d, seg, sb[k].seg);
                        end
                        sb.delete(k);
                        break;
                    end
                end
            end
        end
        prev_sel = sys_rst_n ? sel : 6'd0;
    end

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge sys_clk);
            k++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL timeout pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_case(
        input logic [19:0] v,
        input logic [5:0]  p,
        input logic        s
    );
        @(negedge sys_clk);
        data  = v;
        point = p;
        sign  = s;
        repeat (50) @(negedge sys_clk);
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{i, ref_seg(int'(v), p, s, i)});
        end
        drain();
    endtask

    initial begin
        sys_rst_n = 1'b0;
        data      = '0;
        point     = '0;
        sign      = 1'b0;
        seg_en    = 1'b1;
        repeat (3) @(negedge sys_clk);
        tests++;
        if (sel !== 6'd0 || seg !== 8'hFF) begin
            fails++;
            $display("FAIL reset_out got=%b/%h exp=000000/FF", sel, seg);
        end
        sys_rst_n = 1'b1;
        sb.push_back('{0, 8'hC0});
        drain();

        run_case(20'd1234, 6'b000000, 1'b0);

        // Asynchronous reset in the middle of a digit.
        repeat (2) @(negedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        tests++;
        if (sel !== 6'd0 || seg !== 8'hFF) begin
            fails++;
            $display("FAIL midscan_reset got=%b/%h exp=000000/FF",
                     sel, seg);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        sb.push_back('{0, 8'hC0});
        drain();

        run_case(20'd1_048_575, 6'b000000, 1'b0);
        run_case(20'd1_048_575, 6'b000000, 1'b1);
        run_case(20'd5, 6'b000010, 1'b1);
        run_case(20'd0, 6'b000000, 1'b1);
        run_case(20'd999_999, 6'b100001, 1'b0);
        run_case(20'd1_000_000, 6'b000100, 1'b1);

        // Display off mid-digit, then back on.
        @(negedge sys_clk);
        data  = 20'd70_809;
        point = 6'b000100;
        sign  = 1'b1;
        repeat (50) @(negedge sys_clk);
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{i, ref_seg(70_809, 6'b000100, 1'b1, i)});
        end
        repeat (2) @(negedge sys_clk);
        seg_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        seg_en = 1'b1;
        drain();

        for (int t = 0; t < 20; t++) begin
            logic [19:0] v;
            logic [5:0]  p;
            case ($urandom_range(0, 2))
                0:       v = 20'($urandom_range(0, 999));
                1:       v = 20'($urandom_range(0, 999_999));
                default: v = 20'($urandom);
            endcase
            p = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            run_case(v, p, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
